// File: rtl/gshare_pht_arbiter.sv
`timescale 1ns/1ps
// Arbitrates one single-ported PHT RAM of 2-bit counters between predict reads and
// queued train read-modify-writes, after sweeping the table to weakly not-taken.
module gshare_pht_arbiter #(
   parameter int N      = 7,
   parameter int DEPTH  = 4,
   parameter int STARVE = 8
) (
   input  logic         clk,
   input  logic         areset_n,
   input  logic         pred_req,
   input  logic [N-1:0] pred_index,
   output logic         pred_ready,
   output logic         pred_rsp_valid,
   output logic         pred_rsp_taken,
   input  logic         train_valid,
   input  logic [N-1:0] train_index,
   input  logic         train_taken,
   output logic         train_ready,
   output logic         init_done,
   output logic         pht_en,
   output logic         pht_we,
   output logic [N-1:0] pht_addr,
   output logic [1:0]   pht_wdata,
   input  logic [1:0]   pht_rdata
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE + 1);

   typedef enum logic [1:0] {INIT, IDLE, RMW_WR} state_e;

   typedef struct packed {
      logic [N-1:0] index;
      logic         taken;
   } train_t;

   state_e        state_q,     state_d;
   logic [N-1:0]  init_addr_q, init_addr_d;
   logic          init_done_q, init_done_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
   logic [PW-1:0] rd_ptr_q,    rd_ptr_d;
   logic [CW-1:0] count_q,     count_d;
   logic [SW-1:0] starve_q,    starve_d;
   train_t        fifo_mem_q [DEPTH];

   train_t        head;
   logic          fifo_empty;
   logic          force_train;
   logic          pred_grant;
   logic          train_rd;
   logic          push;
   logic          pop;
   logic [1:0]    ctr_new;

   function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
      if (taken && ctr != 2'b11)  return ctr + 2'b01;
      if (!taken && ctr != 2'b00) return ctr - 2'b01;
      return ctr;
   endfunction

   // Arbitration and handshakes.
   always_comb begin
      head        = fifo_mem_q[rd_ptr_q];
      fifo_empty  = (count_q == '0);
      force_train = (starve_q == SW'(STARVE)) && !fifo_empty;
      pred_ready  = init_done_q && (state_q == IDLE) && !force_train;
      train_ready = init_done_q && (count_q < CW'(DEPTH));
      pred_grant  = pred_req && pred_ready;
      train_rd    = (state_q == IDLE) && !pred_grant && !fifo_empty;
      push        = train_valid && train_ready;
      pop         = (state_q == RMW_WR);
      ctr_new     = sat_update(pht_rdata, head.taken);
   end

   // RAM port is forced quiet while reset is held, even though the FSM sits in INIT.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      pht_en    = 1'b0;
      pht_we    = 1'b0;
      pht_addr  = '0;
      pht_wdata = 2'b00;
      if (areset_n) begin
         case (state_q)
            INIT: begin
               pht_en    = 1'b1;
               pht_we    = 1'b1;
               pht_addr  = init_addr_q;
               pht_wdata = 2'b01;
            end
            IDLE: begin
               if (pred_grant) begin
                  pht_en   = 1'b1;
                  pht_addr = pred_index;
               end else if (train_rd) begin
                  pht_en   = 1'b1;
                  pht_addr = head.index;
               end
            end
            RMW_WR: begin
               pht_en    = 1'b1;
               pht_we    = 1'b1;
               pht_addr  = head.index;
               pht_wdata = ctr_new;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      init_addr_d = init_addr_q;
      init_done_d = init_done_q;
      case (state_q)
         INIT: begin
            init_addr_d = init_addr_q + 1'b1;
            if (init_addr_q == '1) begin
               state_d     = IDLE;
               init_done_d = 1'b1;
            end
         end
         IDLE:    if (train_rd) state_d = RMW_WR;
         RMW_WR:  state_d = IDLE;
         default: state_d = INIT;
      endcase
   end

   always_comb begin
      rsp_valid_d = pred_grant;
      wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d     = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: ;
      endcase
      starve_d = starve_q;
      if (train_rd) begin
         starve_d = '0;
      end else if (pred_grant && !fifo_empty && starve_q != SW'(STARVE)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q     <= INIT;
         init_addr_q <= '0;
         init_done_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         init_addr_q <= init_addr_d;
         init_done_q <= init_done_d;
         rsp_valid_q <= rsp_valid_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         starve_q    <= starve_d;
      end
   end

   // NOTE: FIFO storage is not reset; count_q gates every read, so stale entries are never used.
   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= train_t'{index: train_index, taken: train_taken};
   end

   assign init_done      = init_done_q;
   assign pred_rsp_valid = rsp_valid_q;
   assign pred_rsp_taken = rsp_valid_q & pht_rdata[1];

endmodule

// File: tb/tb_gshare_pht_arbiter.sv
`timescale 1ns/1ps
// Directed bench for gshare_pht_arbiter driving a behavioural single-port PHT RAM.
module tb_gshare_pht_arbiter;

   localparam int N       = 7;
   localparam int DEPTH   = 4;
   localparam int STARVE  = 8;
   localparam int ENTRIES = 1 << N;

   logic         clk = 1'b0;
   logic         areset_n = 1'b0;
   logic         pred_req = 1'b0;
   logic [N-1:0] pred_index = '0;
   logic         pred_ready;
   logic         pred_rsp_valid;
   logic         pred_rsp_taken;
   logic         train_valid = 1'b0;
   logic [N-1:0] train_index = '0;
   logic         train_taken = 1'b0;
   logic         train_ready;
   logic         init_done;
   logic         pht_en;
   logic         pht_we;
   logic [N-1:0] pht_addr;
   logic [1:0]   pht_wdata;
   logic [1:0]   pht_rdata = 2'b11;

   logic [1:0]   ram [ENTRIES] = '{default: 2'b10};
   logic [N-1:0] wr_log [$];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   gshare_pht_arbiter #(.N(N), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
      .clk            (clk),
      .areset_n       (areset_n),
      .pred_req       (pred_req),
      .pred_index     (pred_index),
      .pred_ready     (pred_ready),
      .pred_rsp_valid (pred_rsp_valid),
      .pred_rsp_taken (pred_rsp_taken),
      .train_valid    (train_valid),
      .train_index    (train_index),
      .train_taken    (train_taken),
      .train_ready    (train_ready),
      .init_done      (init_done),
      .pht_en         (pht_en),
      .pht_we         (pht_we),
      .pht_addr       (pht_addr),
      .pht_wdata      (pht_wdata),
      .pht_rdata      (pht_rdata)
   );

   // RAM model: read data appears the cycle after the strobe; post-init writes are logged.
   always @(posedge clk) begin
      if (pht_en) begin
         if (pht_we) begin
            ram[pht_addr] <= pht_wdata;
            if (init_done) wr_log.push_back(pht_addr);
         end else begin
            pht_rdata <= ram[pht_addr];
         end
      end
   end

   initial begin
      #200us;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_low(input string tag);
      check({tag, ".flags"}, 32'({pred_ready, pred_rsp_valid, pred_rsp_taken, train_ready,
                                  init_done, pht_en, pht_we}), 32'(0));
      check({tag, ".bus"}, 32'({pht_addr, pht_wdata}), 32'(0));
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   // Releases reset and follows the sweep: address a is written in cycle a, init_done in cycle 2**N.
   task automatic init_sweep(input string tag);
      int           bad = 0;
      logic [N-1:0] av;
      @(negedge clk);
      areset_n = 1'b1;
      #1;
      check({tag, ".first"}, 32'({pht_en, pht_we, pht_addr, pht_wdata}), 32'({1'b1, 1'b1, 7'd0, 2'b01}));
      for (int a = 0; a < ENTRIES; a++) begin
         if (a > 0) begin
            @(negedge clk);
            #1;
         end
         av = N'(a);
         check({tag, ".sweep"},
               32'({pht_en, pht_we, pht_wdata, pht_addr, pred_ready, train_ready, init_done}),
               32'({1'b1, 1'b1, 2'b01, av, 3'b000}));
      end
      @(negedge clk);
      #1;
      check({tag, ".done"}, 32'({init_done, pred_ready, train_ready, pht_en}), 32'(4'b1110));
      for (int a = 0; a < ENTRIES; a++) if (ram[a] !== 2'b01) bad++;
      check({tag, ".table"}, 32'(bad), 32'(0));
   endtask

   task automatic predict(input string tag, input logic [N-1:0] idx, input logic exp_taken);
      @(negedge clk);
      pred_req   = 1'b1;
      pred_index = idx;
      #1;
      check({tag, ".port"}, 32'({pred_ready, pht_en, pht_we, pht_addr}), 32'({1'b1, 1'b1, 1'b0, idx}));
      @(negedge clk);
      pred_req = 1'b0;
      #1;
      check({tag, ".rsp"}, 32'({pred_rsp_valid, pred_rsp_taken}), 32'({1'b1, exp_taken}));
   endtask

   task automatic train(input string tag, input logic [N-1:0] idx, input logic tk);
      int waited = 0;
      @(negedge clk);
      train_valid = 1'b1;
      train_index = idx;
      train_taken = tk;
      #1;
      while (!train_ready && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      check({tag, ".accept"}, 32'(train_ready), 32'(1));
      @(negedge clk);
      train_valid = 1'b0;
   endtask

   initial begin
      // Reset state and init sweep
      repeat (3) @(negedge clk);
      #1;
      check_all_low("reset");
      init_sweep("init");
      predict("pred5", N'(5), 1'b0);

      // Taken saturation on index 9
      train("t9a", N'(9), 1'b1);
      idle(3);
      check("ctr9.first", 32'(ram[9]), 32'(2'b10));
      train("t9b", N'(9), 1'b1);
      idle(3);
      check("ctr9.second", 32'(ram[9]), 32'(2'b11));
      predict("pred9", N'(9), 1'b1);
      train("t9c", N'(9), 1'b1);
      idle(3);
      check("ctr9.sat", 32'(ram[9]), 32'(2'b11));

      // Not-taken saturation on index 3
      train("t3a", N'(3), 1'b0);
      idle(3);
      check("ctr3.first", 32'(ram[3]), 32'(2'b00));
      for (int i = 0; i < 3; i++) train("t3", N'(3), 1'b0);
      idle(4);
      check("ctr3.sat", 32'(ram[3]), 32'(2'b00));
      predict("pred3", N'(3), 1'b0);

      // Fill the FIFO under continuous predicts, then starvation forces the head
      for (int c = 0; c <= 8; c++) begin
         @(negedge clk);
         pred_req    = 1'b1;
         pred_index  = N'(40);
         train_valid = (c < 4);
         train_index = N'(20 + c);
         train_taken = 1'b1;
         #1;
         check("fill.pred_ready", 32'(pred_ready), 32'(1));
         check("fill.train_ready", 32'(train_ready), 32'(c < 4));
      end
      @(negedge clk);
      train_valid = 1'b0;
      #1;
      check("force.read", 32'({pred_ready, pht_en, pht_we, pht_addr}), 32'({1'b0, 1'b1, 1'b0, 7'd20}));
      @(negedge clk);
      #1;
      check("force.write", 32'({pred_ready, pred_rsp_valid, pht_en, pht_we, pht_addr, pht_wdata}),
            32'({1'b0, 1'b0, 1'b1, 1'b1, 7'd20, 2'b10}));
      @(negedge clk);
      #1;
      check("force.after", 32'({pred_ready, train_ready}), 32'(2'b11));
      @(negedge clk);
      pred_req = 1'b0;
      idle(10);
      for (int i = 0; i < 4; i++) check("fill.ctr", 32'(ram[20 + i]), 32'(2'b10));

      // Same-cycle push and pop at count 2 across pointer wrap
      wr_log.delete();
      begin
         int k = 0;
         for (int p = 0; p <= 17; p++) begin
            @(negedge clk);
            train_valid = (p <= 2) || (p <= 12 && p % 2 == 0);
            train_index = N'(30 + k);
            train_taken = 1'b0;
            if (train_valid) k++;
            #1;
            if (p >= 2 && p <= 12 && p % 2 == 0)
               check("pushpop.rmw", 32'({pht_en, pht_we, train_ready}), 32'(3'b111));
         end
         train_valid = 1'b0;
      end
      check("pushpop.count", 32'(wr_log.size()), 32'(8));
      for (int i = 0; i < 8; i++) begin
         check("pushpop.order", (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFFFF_FFFF, 32'(30 + i));
         check("pushpop.ctr", 32'(ram[30 + i]), 32'(2'b00));
      end

      // Reset during RMW_WR with three updates queued
      for (int p = 0; p < 4; p++) begin
         @(negedge clk);
         train_valid = 1'b1;
         train_index = N'(50 + p);
         train_taken = 1'b1;
      end
      @(negedge clk);
      train_valid = 1'b0;
      #1;
      check("abort.rmw", 32'({pht_en, pht_we, pht_addr}), 32'({1'b1, 1'b1, 7'd51}));
      areset_n = 1'b0;
      #1;
      check_all_low("abort");
      wr_log.delete();
      idle(2);
      check_all_low("abort.held");
      init_sweep("reinit");
      idle(12);
      check("abort.no_writes", 32'(wr_log.size()), 32'(0));
      for (int i = 0; i < 4; i++) check("abort.ctr", 32'(ram[50 + i]), 32'(2'b01));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
